// File: rtl/hash_job_arbiter_if.sv
// Client-side bundle of hash_job_arbiter: job requests, message byte stream,
// and the tagged digest result.
//   slave  modport: seen by the arbiter (requests/bytes in, acks/results out)
//   master modport: seen by the requester side (the mirror image)
// Signals:
//   req_valid/req_len/req_ack       job request, length, one-hot grant
//   byte_valid/byte_data/byte_ready per-requester message byte handshake
//   res_valid/res_id/res_digest/res_err  one-cycle tagged result
//   busy                            arbiter not in IDLE
interface hash_job_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned IDW   = 2
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       byte_valid;
  logic [NREQ*8-1:0]     byte_data;
  logic [NREQ-1:0]       byte_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [31:0]           res_digest;
  logic                  res_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_len, byte_valid, byte_data,
    output req_ack, byte_ready, res_valid, res_id, res_digest, res_err, busy
  );

  modport master (
    output req_valid, req_len, byte_valid, byte_data,
    input  req_ack, byte_ready, res_valid, res_id, res_digest, res_err, busy
  );
endinterface

// File: rtl/hash_job_arbiter.sv
// Shares one full_hash_des_box core between NREQ requesters. Grants jobs
// round-robin, feeds message bytes to the core one per ISSUE with a GAP
// cycle between them (the core's S1/S2 cycle), and captures the digest at a
// fixed latency after the last byte, returning it tagged with the owner id.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (shared with core)
//   bus              client-side interface (slave modport)
//   core_m_valid     core M_valid, high only in ISSUE
//   core_message     core message byte
//   core_counter     core counter: zero-extended job length while busy
//   core_digest      core digest_out
//   core_hash_ready  core hash_ready, only sampled for the error flag
module hash_job_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hash_job_arbiter_if.slave     bus,
  output logic                  core_m_valid,
  output logic [7:0]            core_message,
  output logic [63:0]           core_counter,
  input  logic [31:0]           core_digest,
  input  logic                  core_hash_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_DRAIN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       byte_q, byte_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [31:0]      res_digest_q, res_digest_d;
  logic             res_err_q, res_err_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [LEN_W-1:0] grant_len;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin : rr_scan
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
    grant_len = bus.req_len[grant_id*LEN_W +: LEN_W];
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    len_d        = len_q;
    rem_d        = rem_q;
    byte_d       = byte_q;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_q;
    res_digest_d = res_digest_q;
    res_err_d    = res_err_q;
    bus.req_ack    = '0;
    bus.byte_ready = '0;
    core_m_valid   = 1'b0;
    core_message   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          bus.req_ack[grant_id] = 1'b1;
          id_d   = grant_id;
          len_d  = grant_len;
          rem_d  = grant_len;
          // Cleared so a zero-length job presents 0x00 to the core.
          byte_d = '0;
          if (grant_id == IDW'(NREQ - 1)) rr_ptr_d = '0;
          else                            rr_ptr_d = grant_id + IDW'(1);
          state_d = (grant_len == '0) ? S_ISSUE : S_FETCH;
        end
      end
      S_FETCH: begin
        bus.byte_ready[id_q] = 1'b1;
        if (bus.byte_valid[id_q]) begin
          byte_d  = bus.byte_data[id_q*8 +: 8];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_m_valid = 1'b1;
        core_message = byte_q;
        if (len_q != '0) rem_d = rem_q - LEN_W'(1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (len_q == '0)      state_d = S_DONE;
        else if (rem_q == '0) state_d = S_DRAIN;
        else                  state_d = S_FETCH;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        // Fixed-latency capture; hash_ready edges are not trustworthy
        // because the core holds it high between jobs.
        res_valid_d  = 1'b1;
        res_id_d     = id_q;
        res_digest_d = core_digest;
        res_err_d    = !core_hash_ready;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      byte_q       <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_digest_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      byte_q       <= byte_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_digest_q <= res_digest_d;
      res_err_q    <= res_err_d;
    end
  end

  assign core_counter   = (state_q != S_IDLE) ? 64'(len_q) : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_digest = res_digest_q;
  assign bus.res_err    = res_err_q;

endmodule
